// File: rtl/sm_clk_sequencer_if.sv
// Control/status bundle between the debounced front panel and the CPU cycle sequencer.
interface sm_clk_sequencer_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 8
) ();
    logic [1:0]         mode;
    logic [3:0]         devide;
    logic               stepBtn;
    logic [BURST_W-1:0] burstLen;
    logic               cpuEn;
    logic               busy;
    logic [CNT_W-1:0]   stepCount;

    modport master (
        output mode, devide, stepBtn, burstLen,
        input  cpuEn, busy, stepCount
    );

    modport slave (
        input  mode, devide, stepBtn, burstLen,
        output cpuEn, busy, stepCount
    );
endinterface

// File: rtl/sm_clk_sequencer.sv
// CPU cycle-enable scheduler: halt, divided free-run, single-step and N-step burst.
// Emits one-clk cpuEn pulses and counts every pulse issued since reset.
module sm_clk_sequencer #(
    parameter int unsigned SHIFT   = 16,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 8
) (
    input logic            clk,
    input logic            rst,
    sm_clk_sequencer_if.slave bus
);

    localparam logic [1:0] M_HALT  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b01;
    localparam logic [1:0] M_STEP  = 2'b10;
    localparam logic [1:0] M_BURST = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BURST
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cntr_q, cntr_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               cpu_en_q, cpu_en_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   step_count_q, step_count_d;
    logic               btn_prev_q;

    logic               rise;
    logic               term;
    logic [CNT_W-1:0]   limit;

    // Comparing with >= lets a shrinking devide fire immediately instead of waiting for a wrap.
    always_comb begin
        rise  = bus.stepBtn & ~btn_prev_q;
        limit = (CNT_W'(1) << (SHIFT + 32'(bus.devide))) - CNT_W'(1);
        term  = (cntr_q >= limit);
    end

    // Next-state, prescaler, burst and pulse generation.
    always_comb begin
        state_d     = state_q;
        cntr_d      = cntr_q;
        remaining_d = remaining_q;
        cpu_en_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cntr_d = '0;
                if (bus.mode == M_RUN) begin
                    state_d = S_RUN;
                end else if ((bus.mode == M_STEP) && rise) begin
                    cpu_en_d = 1'b1;
                end else if ((bus.mode == M_BURST) && rise && (bus.burstLen != '0)) begin
                    state_d     = S_BURST;
                    remaining_d = bus.burstLen;
                end
            end

            S_RUN: begin
                if (bus.mode != M_RUN) begin
                    state_d = S_IDLE;
                    cntr_d  = '0;
                end else if (term) begin
                    cpu_en_d = 1'b1;
                    cntr_d   = '0;
                end else begin
                    cntr_d = cntr_q + CNT_W'(1);
                end
            end

            S_BURST: begin
                if (bus.mode != M_BURST) begin
                    state_d     = S_IDLE;
                    cntr_d      = '0;
                    remaining_d = '0;
                end else if (term) begin
                    cpu_en_d    = 1'b1;
                    cntr_d      = '0;
                    remaining_d = remaining_q - BURST_W'(1);
                    if (remaining_q == BURST_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cntr_d = cntr_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = S_IDLE;
                cntr_d      = '0;
                remaining_d = '0;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        step_count_d = step_count_q + CNT_W'(cpu_en_d);
    end

    // Held-high button through reset must not look like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cntr_q       <= '0;
            remaining_q  <= '0;
            cpu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            step_count_q <= '0;
            btn_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cntr_q       <= cntr_d;
            remaining_q  <= remaining_d;
            cpu_en_q     <= cpu_en_d;
            busy_q       <= busy_d;
            step_count_q <= step_count_d;
            btn_prev_q   <= bus.stepBtn;
        end
    end

    assign bus.cpuEn     = cpu_en_q;
    assign bus.busy      = busy_q;
    assign bus.stepCount = step_count_q;

endmodule
